// File: rtl/div_pkg.sv
// Shared definitions for the divider result BCD converter: widths, digit count and FSM states.
package div_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned BCD_W     = 4;

    function automatic int unsigned digits_for(input int unsigned w);
        return (w + 2) / 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dd_channel.sv
// One double-dabble lane: binary shift register plus BCD accumulator with add-3 adjust.
module dd_channel
    import div_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = digits_for(WIDTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic                      i_step,
    input  logic [WIDTH-1:0]          i_din,
    output logic [BCD_W*DIGITS-1:0]   o_bcd_next
);

    logic [WIDTH-1:0]        r_bin;
    logic [BCD_W*DIGITS-1:0] r_bcd;
    logic [BCD_W*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_bcd[d*BCD_W +: BCD_W] >= 4'd5)
                w_adj[d*BCD_W +: BCD_W] = r_bcd[d*BCD_W +: BCD_W] + 4'd3;
        end
    end

    // Exposed so the top can capture the final iteration on the same edge it happens.
    assign o_bcd_next = {w_adj[BCD_W*DIGITS-2:0], r_bin[WIDTH-1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin <= '0;
            r_bcd <= '0;
        end else if (i_load) begin
            r_bin <= i_din;
            r_bcd <= '0;
        end else if (i_step) begin
            r_bin <= r_bin << 1;
            r_bcd <= o_bcd_next;
        end
    end

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider quotient/remainder pair to packed BCD over valid/ready handshakes.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = digits_for(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        quotient,
    input  logic [WIDTH-1:0]        remainder,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] q_bcd,
    output logic [BCD_W*DIGITS-1:0] r_bcd,
    output logic                    busy
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_cnt;
    logic                    w_load;
    logic                    w_step;
    logic                    w_last;
    logic [BCD_W*DIGITS-1:0] w_q_next;
    logic [BCD_W*DIGITS-1:0] w_r_next;
    logic [BCD_W*DIGITS-1:0] r_q_bcd;
    logic [BCD_W*DIGITS-1:0] r_r_bcd;

    dd_channel #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_chan (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_din      (quotient),
        .o_bcd_next (w_q_next)
    );

    dd_channel #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_chan (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_din      (remainder),
        .o_bcd_next (w_r_next)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // rst gates in_ready so no accept can be seen during reset.
    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        busy      = (r_state == SHIFT) || (r_state == DONE);
        w_load    = in_ready && in_valid;
        w_step    = (r_state == SHIFT);
        w_last    = w_step && (r_cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
        end else begin
            if (w_load)      r_cnt <= '0;
            else if (w_step) r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_q_bcd <= w_q_next;
                r_r_bcd <= w_r_next;
            end
        end
    end

    assign q_bcd = r_q_bcd;
    assign r_bcd = r_r_bcd;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: reset, conversions, sweep, backpressure, ignored input, mid-run reset.
`timescale 1ns/1ps
module tb_div_result_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_result_bcd #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .busy      (busy)
    );

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] b;
        b[3:0]  = 4'(v % 10);
        b[7:4]  = 4'((v / 10) % 10);
        b[11:8] = 4'(v / 100);
        return b;
    endfunction

    // Waits (bounded) for in_ready, then presents one pair for exactly one accept edge.
    task automatic accept(input logic [7:0] q, input logic [7:0] r, output time t_acc);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        quotient  = q;
        remainder = r;
        in_valid  = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; quotient = '0; remainder = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (q_bcd !== 12'h000 || r_bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h/%h want 000/000", q_bcd, r_bcd); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        time t; int cyc;
        accept(8'd8, 8'd2, t);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_out(cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", cyc); end
        checks++; if (q_bcd !== 12'h008 || r_bcd !== 12'h002) begin errors++; $display("FAIL basic_value got %h/%h want 008/002", q_bcd, r_bcd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_no_turnaround got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_return_idle got ov=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_corners;
        time t; int cyc;
        accept(8'd255, 8'd255, t);
        wait_out(cyc);
        checks++; if (q_bcd !== 12'h255 || r_bcd !== 12'h255) begin errors++; $display("FAIL corner_max got %h/%h want 255/255", q_bcd, r_bcd); end
        @(posedge clk); #1;
        accept(8'd0, 8'd0, t);
        wait_out(cyc);
        checks++; if (q_bcd !== 12'h000 || r_bcd !== 12'h000) begin errors++; $display("FAIL corner_zero got %h/%h want 000/000", q_bcd, r_bcd); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        time t, t_first; int cyc;
        logic [11:0] eq, er;
        t_first = 0;
        for (int i = 0; i < 256; i++) begin
            accept(8'(i), 8'(255 - i), t);
            if (i == 0) t_first = t;
            wait_out(cyc);
            eq = ref_bcd(i);
            er = ref_bcd(255 - i);
            checks++; if (q_bcd !== eq) begin errors++; $display("FAIL sweep_q[%0d] got %h want %h", i, q_bcd, eq); end
            checks++; if (r_bcd !== er) begin errors++; $display("FAIL sweep_r[%0d] got %h want %h", i, r_bcd, er); end
            @(posedge clk); #1;
        end
        checks++; if (t - t_first !== 255 * 100) begin errors++; $display("FAIL sweep_throughput got %0t want %0d", t - t_first, 255 * 100); end
    endtask

    task automatic test_backpressure;
        time t; int cyc;
        out_ready = 1'b0;
        accept(8'd11, 8'd2, t);
        wait_out(cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL bp_latency got %0d want 8", cyc); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_bcd !== 12'h011 || r_bcd !== 12'h002) begin
                errors++; $display("FAIL bp_hold[%0d] got ov=%b rdy=%b %h/%h want 1/0 011/002", k, out_valid, in_ready, q_bcd, r_bcd);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b rdy=%b want 0/1", out_valid, in_ready); end
        checks++; if (q_bcd !== 12'h011 || r_bcd !== 12'h002) begin errors++; $display("FAIL bp_retain got %h/%h want 011/002", q_bcd, r_bcd); end
    endtask

    task automatic test_ignore_in_valid;
        time t; int cyc;
        accept(8'd20, 8'd3, t);
        @(posedge clk); #1;
        quotient = 8'd99; remainder = 8'd99; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; quotient = 8'd77; remainder = 8'd66;
        wait_out(cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL ignore_latency got %0d want 6", cyc); end
        checks++; if (q_bcd !== 12'h020 || r_bcd !== 12'h003) begin errors++; $display("FAIL ignore_value got %h/%h want 020/003", q_bcd, r_bcd); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        time t; int cyc;
        accept(8'd200, 8'd45, t);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_flags got ov=%b busy=%b want 0/0", out_valid, busy); end
        checks++; if (q_bcd !== 12'h000 || r_bcd !== 12'h000) begin errors++; $display("FAIL rstmid_bcd got %h/%h want 000/000", q_bcd, r_bcd); end
        rst = 1'b0;
        #1;
        accept(8'd9, 8'd0, t);
        wait_out(cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL rstmid_latency got %0d want 8", cyc); end
        checks++; if (q_bcd !== 12'h009 || r_bcd !== 12'h000) begin errors++; $display("FAIL rstmid_fresh got %h/%h want 009/000", q_bcd, r_bcd); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_sweep();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Sequential binary-to-BCD converter directly downstream of the 8-bit restoring divider. It accepts one quotient/remainder pair per transaction over a valid/ready handshake. Both values are converted in parallel with the shift-and-add-3 (double-dabble) algorithm, and the result is presented as packed BCD digits for display or logging stages.

## Interface
Parameters:
- WIDTH, 8, bit width of the quotient and remainder inputs.
- DIGITS, (WIDTH+2)/3, BCD digits per output. Derived; 3 at the default.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  quotient/remainder pair is valid.
- in_ready  output  1  block can accept a pair (IDLE only).
- quotient  input  WIDTH  binary quotient from the divider.
- remainder  input  WIDTH  binary remainder from the divider.
- out_valid  output  1  BCD result available.
- out_ready  input  1  consumer accepts the result.
- q_bcd  output  4*DIGITS  quotient in BCD; digit 0 is in bits [3:0].
- r_bcd  output  4*DIGITS  remainder in BCD; same packing as q_bcd.
- busy  output  1  high in SHIFT and DONE.

## Operation
- Three states:
  - IDLE: in_ready=1.
  - SHIFT: conversion in progress; bit counter runs 0..WIDTH-1.
  - DONE: out_valid=1.
- IDLE → SHIFT on in_valid && in_ready:
  - Each channel loads its binary shift register from its input.
  - Each channel clears its BCD accumulator.
  - Bit counter clears.
- SHIFT, one iteration per cycle, per channel:
  - Every BCD digit ≥5 gets +3 (4-bit add, no carry out).
  - The {BCD, binary} register then shifts left by 1; the binary MSB enters BCD bit 0.
- SHIFT → DONE when the counter reaches WIDTH-1 on the iteration edge.
  - The same edge writes the final BCD into q_bcd/r_bcd.
  - out_valid is asserted on that edge.
- DONE → IDLE on out_valid && out_ready.
  - q_bcd/r_bcd keep their last values until the next DONE.
- in_valid outside IDLE is ignored. Upstream must hold data until its transfer.
- Inputs are sampled only on the accept edge; later changes to quotient/remainder do not affect the conversion in flight.
- Overflow cannot occur: 10^DIGITS > 2^WIDTH for all WIDTH ≥ 1.

## Timing
- Reset values: state IDLE, out_valid=0, busy=0, q_bcd=0, r_bcd=0, counter=0.
- in_ready=0 while rst is high, 1 in the first cycle after release.
- Latency: accept on edge N → out_valid high from edge N+WIDTH (8 cycles at the default).
- Throughput:
  - out_ready tied high: one transaction per WIDTH+2 cycles.
  - in_ready is not asserted in the same cycle as the output transfer (no same-cycle turnaround).
- Backpressure: while out_valid && !out_ready, q_bcd, r_bcd and out_valid stay stable for any number of cycles.
- Reset mid-SHIFT or mid-DONE:
  - Abort the conversion and return to reset values on the next edge.
  - No partial result is ever presented.
- rst has priority over every handshake event in the same cycle.

## Structure
- Shared package/header `div_pkg`:
  - WIDTH default and the DIGITS derivation.
  - State encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - BCD digit width constant (4).
- Sub-module `dd_channel`:
  - Holds the binary register, BCD accumulator, add-3 adjust and shift for one value.
  - Controlled by `load` and `step` inputs.
  - Instantiated twice (quotient, remainder).
- Top level owns the FSM, the counter, the handshake and the output registers.

## Test plan
- quotient=8, remainder=2 (42/5) with out_ready=1 → out_valid exactly 8 cycles after accept; q_bcd=12'h008, r_bcd=12'h002.
- quotient=255, remainder=255 → q_bcd=12'h255, r_bcd=12'h255; quotient=0, remainder=0 → both 12'h000.
- Exhaustive sweep of 0..255 on both channels with out_ready=1 → every result matches a reference model; one transaction per 10 cycles.
- Backpressure:
  - Stimulus: quotient=11, remainder=2 (123/11), out_ready low for 5 cycles after out_valid.
  - Required: outputs hold 12'h011/12'h002; in_ready stays 0; transfer completes on the first out_ready cycle.
- in_valid pulsed with new data during SHIFT → ignored; the result reflects the originally accepted pair.
- rst asserted at iteration 4 → next cycle out_valid=0, busy=0, outputs 0. A fresh pair (9, 0) then gives q_bcd=12'h009, r_bcd=12'h000.
